// File: rtl/apb_uart_fifo.sv
// APB slave UART with TX/RX FIFOs, programmable parity/stop bits, sticky errors and a maskable irq.
// Serial line is LSB first; each FSM has its own baud counter running 0..div.
module apb_uart_fifo #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        pslverr,
    input  logic        serial_in,
    output logic        data_out,
    output logic        irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Control and status registers
    logic [15:0] div;
    logic        parity_en, parity_odd, two_stop, tx_en, rx_en;
    logic [2:0]  irq_en;
    logic        overrun, frame_err, parity_err;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_level, rx_level;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_push_req;
    logic [DATA_BITS-1:0] tx_head;

    // APB decode
    logic       access, wr_acc, rd_acc;
    logic [2:0] reg_idx;
    logic [2:0] w1c;
    logic       unused_bits;

    assign access  = PSEL & PENABLE;
    assign wr_acc  = access & PWRITE;
    assign rd_acc  = access & ~PWRITE;
    assign reg_idx = PADDR[4:2];
    assign w1c     = (wr_acc && reg_idx == 3'd2) ? PWDATA[6:4] : 3'b000;
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:21]};

    assign tx_level = tx_wp - tx_rp;
    assign rx_level = rx_wp - rx_rp;
    assign tx_empty = (tx_level == '0);
    assign rx_empty = (rx_level == '0);
    assign tx_full  = (tx_level == PW'(FIFO_DEPTH));
    assign rx_full  = (rx_level == PW'(FIFO_DEPTH));
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    assign tx_push = wr_acc && reg_idx == 3'd0 && (!tx_full || tx_pop);
    assign rx_pop  = rd_acc && reg_idx == 3'd1 && !rx_empty;
    assign rx_push = rx_push_req && (!rx_full || rx_pop);

    // TX FSM registers
    tx_state_t            tx_state, tx_state_n;
    logic [15:0]          tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [BW-1:0]        tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_par, tx_par_n, tx_pen, tx_pen_n, tx_two, tx_two_n;
    logic                 tx_stop2, tx_stop2_n, data_out_n, tx_load, tx_tick, tx_busy;

    // RX FSM registers
    rx_state_t            rx_state, rx_state_n;
    logic [15:0]          rx_cnt, rx_cnt_n, rx_div, rx_div_n, rx_half_m1;
    logic [16:0]          rx_div_p1;
    logic [BW-1:0]        rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_pen, rx_pen_n, rx_odd, rx_odd_n;
    logic                 rx_s1, rx_s2, rx_prev, rx_tick, rx_fall;
    logic                 frame_set, parity_set, overrun_set;

    assign tx_busy     = (tx_state != TX_IDLE);
    assign overrun_set = rx_push_req && !rx_push;

    // Combinational read data and error response
    always_comb begin
        PRDATA  = 32'd0;
        pslverr = 1'b0;
        case (reg_idx)
            3'd1: if (!rx_empty) PRDATA = 32'(rx_mem[rx_rp[AW-1:0]]);
            3'd2: PRDATA = {8'd0, 8'(rx_level), 8'(tx_level), tx_busy, parity_err, frame_err,
                            overrun, rx_full, rx_empty, tx_full, tx_empty};
            3'd3: PRDATA = {11'd0, rx_en, tx_en, two_stop, parity_odd, parity_en, div};
            3'd4: PRDATA = {29'd0, irq_en};
            default: PRDATA = 32'd0;
        endcase
        if (access) begin
            if (reg_idx > 3'd4)
                pslverr = 1'b1;
            else if (PWRITE && reg_idx == 3'd0 && tx_full && !tx_pop)
                pslverr = 1'b1;
            else if (!PWRITE && reg_idx == 3'd1 && rx_empty)
                pslverr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= 16'(DEFAULT_DIV);
            parity_en  <= 1'b0;
            parity_odd <= 1'b0;
            two_stop   <= 1'b0;
            tx_en      <= 1'b1;
            rx_en      <= 1'b1;
            irq_en     <= 3'b000;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_acc && reg_idx == 3'd3) begin
                div        <= PWDATA[15:0];
                parity_en  <= PWDATA[16];
                parity_odd <= PWDATA[17];
                two_stop   <= PWDATA[18];
                tx_en      <= PWDATA[19];
                rx_en      <= PWDATA[20];
            end
            if (wr_acc && reg_idx == 3'd4) irq_en <= PWDATA[2:0];
            overrun    <= overrun_set | (overrun & ~w1c[0]);
            frame_err  <= frame_set   | (frame_err & ~w1c[1]);
            parity_err <= parity_set  | (parity_err & ~w1c[2]);
            irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty) |
                   (irq_en[2] & (overrun | frame_err | parity_err));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= PWDATA[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // TX next state: frame config and divisor are latched at frame start / each wrap
    assign tx_tick = (tx_cnt >= tx_div);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_idx_n   = tx_idx;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        tx_pen_n   = tx_pen;
        tx_two_n   = tx_two;
        tx_stop2_n = tx_stop2;
        data_out_n = data_out;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        if (tx_state != TX_IDLE) begin
            if (tx_tick) begin
                tx_cnt_n = 16'd0;
                tx_div_n = div;
            end else begin
                tx_cnt_n = tx_cnt + 16'd1;
            end
        end
        case (tx_state)
            TX_IDLE: begin
                data_out_n = 1'b1;
                tx_cnt_n   = 16'd0;
                tx_div_n   = div;
                if (!tx_empty && tx_en) tx_load = 1'b1;
            end
            TX_START: if (tx_tick) begin
                tx_state_n = TX_DATA;
                tx_idx_n   = '0;
                data_out_n = tx_sh[0];
            end
            TX_DATA: if (tx_tick) begin
                if (tx_idx == LAST_BIT) begin
                    if (tx_pen) begin
                        tx_state_n = TX_PARITY;
                        data_out_n = tx_par;
                    end else begin
                        tx_state_n = TX_STOP;
                        data_out_n = 1'b1;
                        tx_stop2_n = 1'b0;
                    end
                end else begin
                    tx_sh_n    = tx_sh >> 1;
                    tx_idx_n   = tx_idx + BW'(1);
                    data_out_n = tx_sh[1];
                end
            end
            TX_PARITY: if (tx_tick) begin
                tx_state_n = TX_STOP;
                data_out_n = 1'b1;
                tx_stop2_n = 1'b0;
            end
            TX_STOP: if (tx_tick) begin
                if (tx_two && !tx_stop2) begin
                    tx_stop2_n = 1'b1;
                end else if (!tx_empty && tx_en) begin
                    tx_load = 1'b1;
                end else begin
                    tx_state_n = TX_IDLE;
                    data_out_n = 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_n = TX_START;
            tx_cnt_n   = 16'd0;
            tx_div_n   = div;
            tx_sh_n    = tx_head;
            tx_par_n   = (^tx_head) ^ parity_odd;
            tx_pen_n   = parity_en;
            tx_two_n   = two_stop;
            data_out_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_div   <= 16'(DEFAULT_DIV);
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
            tx_two   <= 1'b0;
            tx_stop2 <= 1'b0;
            data_out <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_idx   <= tx_idx_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx_pen   <= tx_pen_n;
            tx_two   <= tx_two_n;
            tx_stop2 <= tx_stop2_n;
            data_out <= data_out_n;
        end
    end

    // RX next state: start bit checked at half period, later bits at full periods
    assign rx_tick    = (rx_cnt >= rx_div);
    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_div_p1  = 17'(rx_div) + 17'd1;
    assign rx_half_m1 = (rx_div_p1[16:1] == 16'd0) ? 16'd0 : rx_div_p1[16:1] - 16'd1;

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_div_n    = rx_div;
        rx_idx_n    = rx_idx;
        rx_sh_n     = rx_sh;
        rx_pen_n    = rx_pen;
        rx_odd_n    = rx_odd;
        rx_push_req = 1'b0;
        frame_set   = 1'b0;
        parity_set  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = 16'd0;
                rx_div_n = div;
                if (rx_en && rx_fall) begin
                    rx_state_n = RX_START;
                    rx_pen_n   = parity_en;
                    rx_odd_n   = parity_odd;
                end
            end
            RX_START: begin
                if (rx_cnt >= rx_half_m1) begin
                    rx_cnt_n   = 16'd0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_DATA, RX_PARITY, RX_STOP: begin
                if (rx_tick) begin
                    rx_cnt_n = 16'd0;
                    rx_div_n = div;
                    if (rx_state == RX_DATA) begin
                        rx_sh_n = {rx_s2, rx_sh[DATA_BITS-1:1]};
                        if (rx_idx == LAST_BIT)
                            rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
                        else
                            rx_idx_n = rx_idx + BW'(1);
                    end else if (rx_state == RX_PARITY) begin
                        parity_set = (rx_s2 != ((^rx_sh) ^ rx_odd));
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_push_req = 1'b1;
                        frame_set   = ~rx_s2;
                        rx_state_n  = RX_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_div   <= 16'(DEFAULT_DIV);
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_pen   <= 1'b0;
            rx_odd   <= 1'b0;
        end else begin
            rx_s1    <= serial_in;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_idx   <= rx_idx_n;
            rx_sh    <= rx_sh_n;
            rx_pen   <= rx_pen_n;
            rx_odd   <= rx_odd_n;
        end
    end
endmodule
